// File: rtl/spi_master_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_rx_deser
// Purpose  : Receive deserializer for the AXI SPI master. Samples SDI on
//            rx_edge strobes in standard (sdi1) or quad (sdi3..sdi0) mode,
//            packs MSB-first into 32-bit words and hands them out through a
//            valid/ready holding register. Stalls the SPI clock generator
//            via clk_en_o when a completed word could not be stored.
// Ports    : clk, rstn (async, active-low)
//            en, rx_edge, sdi0..sdi3        - sampling control / serial data
//            en_quad_in, counter_in[15:0],
//            counter_in_upd                 - transfer setup / restart
//            rx_done                        - pulse after the final edge
//            data[31:0], data_valid,
//            data_ready                     - word output handshake
//            clk_en_o                       - permission for next SPI edge
// Config   : SPI_MASTER_RX_ENDIAN_SWAP_EN - byte-swap words before storing
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_rx_deser (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        rx_edge,
    input  logic        sdi0,
    input  logic        sdi1,
    input  logic        sdi2,
    input  logic        sdi3,
    input  logic        en_quad_in,
    input  logic [15:0] counter_in,
    input  logic        counter_in_upd,
    output logic        rx_done,
    output logic [31:0] data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        clk_en_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RX   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        quad_q, quad_d;
    logic [15:0] target_q, target_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    logic [15:0] cnt_inc;
    logic        last_edge;
    logic        word_edge;
    logic        completes;
    logic        clk_en;
    logic        sample;
    logic [31:0] shift_next;
    logic [31:0] word_out;
    logic [15:0] load_target;

    // Everything here depends only on registered state (plus data_ready for
    // the stall), so clk_en_o has no combinational path from rx_edge.
    always_comb begin
        cnt_inc     = cnt_q + 16'd1;
        last_edge   = (cnt_inc == target_q);
        word_edge   = quad_q ? (cnt_inc[2:0] == 3'd0) : (cnt_inc[4:0] == 5'd0);
        completes   = last_edge | word_edge;
        clk_en      = !((state_q == RX) && completes && valid_q && !data_ready);
        sample      = (state_q == RX) && en && rx_edge && clk_en;
        shift_next  = quad_q ? {shift_q[27:0], sdi3, sdi2, sdi1, sdi0}
                             : {shift_q[30:0], sdi1};
        load_target = en_quad_in ? {2'b00, counter_in[15:2]} : counter_in;
    end

`ifdef SPI_MASTER_RX_ENDIAN_SWAP_EN
    assign word_out = {shift_next[7:0], shift_next[15:8],
                       shift_next[23:16], shift_next[31:24]};
`else
    assign word_out = shift_next;
`endif

    always_comb begin
        state_d  = state_q;
        quad_d   = quad_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        done_d   = 1'b0;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        if (counter_in_upd) begin
            // Restart: the holding register is deliberately left alone so a
            // word already delivered to it is not lost.
            quad_d   = en_quad_in;
            target_d = load_target;
            cnt_d    = 16'd0;
            shift_d  = 32'd0;
            if (load_target == 16'd0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RX;
            end
        end else if (sample) begin
            cnt_d = cnt_inc;
            if (completes) begin
                // Shift register is cleared per word, so a partial final
                // word comes out right-justified with zero upper bits.
                data_d  = word_out;
                valid_d = 1'b1;
                shift_d = 32'd0;
            end else begin
                shift_d = shift_next;
            end
            if (last_edge) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            quad_q   <= 1'b0;
            target_q <= 16'd0;
            cnt_q    <= 16'd0;
            shift_q  <= 32'd0;
            data_q   <= 32'd0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            quad_q   <= quad_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign rx_done    = done_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign clk_en_o   = clk_en;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_rx_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_rx_deser
// Purpose  : Self-checking bench for spi_master_rx_deser. A driver issues
//            transfers and pushes expected words into a scoreboard queue; a
//            monitor pops and compares on each data handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_rx_deser;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        rx_edge = 1'b0;
    logic        sdi0 = 1'b0, sdi1 = 1'b0, sdi2 = 1'b0, sdi3 = 1'b0;
    logic        en_quad_in = 1'b0;
    logic [15:0] counter_in = 16'd0;
    logic        counter_in_upd = 1'b0;
    logic        data_ready = 1'b0;
    logic        rx_done;
    logic [31:0] data;
    logic        data_valid;
    logic        clk_en_o;

    spi_master_rx_deser dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .rx_edge        (rx_edge),
        .sdi0           (sdi0),
        .sdi1           (sdi1),
        .sdi2           (sdi2),
        .sdi3           (sdi3),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .rx_done        (rx_done),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .clk_en_o       (clk_en_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  forced[$];
    logic [31:0] e_word;
    int          produced = 0;
    int          accepted = 0;
    logic        exp_done = 1'b0;
    logic        pend_done = 1'b0;
    logic        mon_en = 1'b0;

    // Reference transfer state (bit-count level, not RTL structure)
    bit          quad = 1'b0;
    int          target = 0;
    int          edges_done = 0;
    bit          in_rx = 1'b0;
    logic [31:0] acc = 32'd0;

    function automatic logic [31:0] model_word(input logic [31:0] v);
`ifdef SPI_MASTER_RX_ENDIAN_SWAP_EN
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
        return v;
`endif
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (rx_done !== exp_done) begin
                errors++;
                $display("FAIL rx_done: got %b expected %b at %0t", rx_done, exp_done, $time);
            end
            if (data_valid === 1'b1 && data_ready === 1'b1) begin
                accepted++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL data: got unexpected word %h, expected none at %0t", data, $time);
                end else begin
                    e_word = exp_q.pop_front();
                    if (data !== e_word) begin
                        errors++;
                        $display("FAIL data: got %h expected %h at %0t", data, e_word, $time);
                    end
                end
            end
        end
    end

    task automatic cycle_start();
        @(posedge clk);
        #1;
        exp_done       = pend_done;
        pend_done      = 1'b0;
        rx_edge        = 1'b0;
        counter_in_upd = 1'b0;
    endtask

    task automatic load(input bit q, input logic [15:0] cnt);
        cycle_start();
        en_quad_in     = q;
        counter_in     = cnt;
        counter_in_upd = 1'b1;
        quad           = q;
        target         = q ? int'(cnt) / 4 : int'(cnt);
        edges_done     = 0;
        acc            = 32'd0;
        in_rx          = (target != 0);
        if (target == 0) pend_done = 1'b1;
    endtask

    // One accepted sampling edge in the reference model.
    task automatic account(input logic [3:0] nib);
        int per;
        per = quad ? 8 : 32;
        edges_done++;
        if (forced.size() != 0) void'(forced.pop_front());
        acc = quad ? ((acc << 4) | {28'd0, nib}) : ((acc << 1) | {31'd0, nib[1]});
        if ((edges_done % per) == 0 || edges_done == target) begin
            exp_q.push_back(model_word(acc));
            produced++;
            acc = 32'd0;
        end
        if (edges_done == target) begin
            pend_done = 1'b1;
            in_rx     = 1'b0;
        end
    endtask

    // ready_mode: 0 always ready, 1 random, 2 hold off until stalled 5 cycles, 3 never
    task automatic run_edges(input int n_edges, input int ready_mode,
                             input int en_pct, input bit viol);
        int   stall;
        int   guard;
        bit   nc;
        bit   exp_ce;
        logic [3:0] nib;
        stall = 0;
        guard = 0;
        while (edges_done < n_edges) begin
            cycle_start();
            guard++;
            if (guard > 5000) begin
                checks++;
                errors++;
                $display("FAIL timeout: edges got %0d expected %0d", edges_done, n_edges);
                break;
            end
            case (ready_mode)
                0:       data_ready = 1'b1;
                1:       data_ready = 1'($urandom_range(0, 1));
                2:       data_ready = (stall >= 5);
                default: data_ready = 1'b0;
            endcase
            #1;
            nc     = (((edges_done + 1) % (quad ? 8 : 32)) == 0) || (edges_done + 1 == target);
            exp_ce = !(in_rx && nc && (produced - accepted) > 0 && !data_ready);
            checks++;
            if (clk_en_o !== exp_ce) begin
                errors++;
                $display("FAIL clk_en_o: got %b expected %b at %0t", clk_en_o, exp_ce, $time);
            end
            if (!exp_ce) stall++;
            en  = ($urandom_range(0, 99) < en_pct);
            nib = 4'($urandom);
            if (forced.size() != 0) begin
                if (quad) nib = forced[0];
                else      nib[1] = forced[0][1];
            end
            {sdi3, sdi2, sdi1, sdi0} = nib;
            if (exp_ce) rx_edge = ($urandom_range(0, 3) != 0);
            else        rx_edge = viol && ($urandom_range(0, 1) == 1);
            if (rx_edge && en && exp_ce) account(nib);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 || pend_done || exp_done) begin
            cycle_start();
            data_ready = 1'b1;
            en         = 1'b1;
            #1;
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d words left, expected 0", exp_q.size());
                break;
            end
            checks++;
            if (clk_en_o !== 1'b1) begin
                errors++;
                $display("FAIL clk_en_o_idle: got %b expected 1 at %0t", clk_en_o, $time);
            end
        end
        repeat (2) cycle_start();
    endtask

    task automatic push_std(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            forced.push_back({2'b00, v[i], 1'b0});
        end
    endtask

    task automatic push_quad(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            forced.push_back(v[i*4 +: 4]);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        check_val("reset_data", data, 32'd0);
        check_val("reset_valid", {31'd0, data_valid}, 32'd0);
        check_val("reset_done", {31'd0, rx_done}, 32'd0);
        check_val("reset_clk_en", {31'd0, clk_en_o}, 32'd1);
        @(negedge clk);
        rstn   = 1'b1;
        en     = 1'b1;
        mon_en = 1'b1;

        // Standard 32 bits
        push_std(32'hA5C3_0F96, 32);
        load(1'b0, 16'd32);
        run_edges(32, 0, 100, 1'b0);
        drain();

        // Quad 64 bits, two words
        push_quad(32'h1234_5678, 8);
        push_quad(32'h9ABC_DEF0, 8);
        load(1'b1, 16'd64);
        run_edges(16, 0, 100, 1'b0);
        drain();

        // Standard 12 bits, partial word
        push_std(32'h0000_0ABC, 12);
        load(1'b0, 16'd12);
        run_edges(12, 0, 100, 1'b0);
        drain();

        // Quad 96 bits with back-pressure
        load(1'b1, 16'd96);
        run_edges(24, 2, 100, 1'b1);
        drain();

        // Restart after 10 edges, then 8 fresh bits
        load(1'b0, 16'd100);
        run_edges(10, 0, 100, 1'b0);
        push_std(32'h0000_005A, 8);
        load(1'b0, 16'd8);
        run_edges(8, 0, 100, 1'b0);
        drain();

        // Zero-length transfers (standard and quad with low bits ignored)
        load(1'b0, 16'd0);
        drain();
        load(1'b1, 16'd3);
        drain();

        // Randomized transfers
        for (int t = 0; t < 25; t++) begin
            logic [15:0] c;
            bit          q;
            q = 1'($urandom_range(0, 1));
            c = 16'($urandom_range(0, 200));
            load(q, c);
            run_edges(q ? int'(c) / 4 : int'(c), 1, 70, 1'b1);
            drain();
        end

        // Reset while a word is pending
        load(1'b0, 16'd40);
        run_edges(32, 3, 100, 1'b0);
        repeat (3) cycle_start();
        check_val("pending_valid", {31'd0, data_valid}, 32'd1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_val("rst_mid_valid", {31'd0, data_valid}, 32'd0);
        check_val("rst_mid_data", data, 32'd0);
        check_val("rst_mid_clk_en", {31'd0, clk_en_o}, 32'd1);
        check_val("rst_mid_done", {31'd0, rx_done}, 32'd0);
        exp_q.delete();
        forced.delete();
        produced = 0;
        accepted = 0;
        in_rx    = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Short transfer after reset recovery
        push_std(32'h0000_0003, 2);
        load(1'b0, 16'd2);
        run_edges(2, 0, 100, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_rx_deser.md
# spi_master_rx_deser

Receive deserializer for the AXI SPI master. It samples SDI on the controller's `spi_rise` strobes in standard (1-bit, `sdi1`) or quad (4-bit) mode and packs the bits into 32-bit words. Words are presented to the RX data path through a valid/ready holding register. It reports end of reception (`rx_done`) to the controller, and stalls the SPI clock through `clk_en_o` when the consumer applies back-pressure.

## Interface
Parameters:
- none (word width fixed at 32, length counter fixed at 16 bits)

Ports:
- `clk` — in, 1 — system clock
- `rstn` — in, 1 — asynchronous, active-low reset
- `en` — in, 1 — receive enable; `rx_edge` is ignored while low
- `rx_edge` — in, 1 — single-cycle sample strobe (SPI rising edge)
- `sdi0`..`sdi3` — in, 1 each — serial inputs; standard mode uses `sdi1` only
- `en_quad_in` — in, 1 — quad mode select, latched on `counter_in_upd`
- `counter_in` — in, 16 — number of bits to receive
- `counter_in_upd` — in, 1 — load `counter_in` and `en_quad_in`, restart the transfer
- `rx_done` — out, 1 — one-cycle pulse when the final bit has been sampled
- `data` — out, 32 — received word
- `data_valid` — out, 1 — `data` holds an unconsumed word
- `data_ready` — in, 1 — consumer accepts `data`
- `clk_en_o` — out, 1 — permission for the clock generator to produce the next edge

## Operation
- State machine:
  - IDLE → RX on `counter_in_upd`.
  - RX → IDLE on the final edge. The `rx_done` pulse is issued in the cycle after that edge.
  - `counter_in_upd` in any state reloads the transfer and enters RX.
- Load behaviour:
  - `target` = `counter_in[15:2]` (zero-extended) in quad mode, `counter_in` in standard mode.
  - `counter_in[1:0]` is ignored in quad mode.
  - Edge counter and shift register are cleared.
  - Holding register is untouched.
- `target` == 0: enter IDLE and pulse `rx_done` next cycle; no word is produced.
- Sampling (RX, `en`=1, `rx_edge`=1):
  - Standard: shift ← {shift[30:0], `sdi1`}.
  - Quad: shift ← {shift[27:0], `sdi3`, `sdi2`, `sdi1`, `sdi0`}.
  - MSB first in both modes.
  - Edge counter increments.
- Word boundary:
  - A word completes every 32 bits (32 standard edges or 8 quad edges), or on the final edge.
  - The completed value, including that edge's bits, moves to the holding register; `data_valid` is set.
  - The shift register is cleared for the next word.
  - A partial final word is right-justified with upper bits zero.
- Holding register:
  - `data_valid` stays set until `data_valid` & `data_ready`.
  - Accept and refill in the same cycle is allowed; `data_valid` stays 1 with the new word.
- Back-pressure: `clk_en_o` = 0 iff in RX, the next edge completes a word, and `data_valid` & ~`data_ready`. Otherwise `clk_en_o` = 1, including in IDLE.
- `rx_edge` while `clk_en_o` = 0 is a protocol violation: the edge is ignored (no shift, no count).
- `en` low mid-transfer: counters and shift register hold; reception resumes when `en` returns.

## Timing
- Reset values:
  - `data` = 0, `data_valid` = 0, `rx_done` = 0, `clk_en_o` = 1
  - state IDLE, counters 0
- Latency:
  - `rx_edge` at cycle N completing a word → `data_valid`=1 and `data` updated at N+1.
  - Final edge at N → `rx_done`=1 at N+1 only.
- `clk_en_o` is combinational from registered state and `data_ready`, with no path from `rx_edge`.
- Reset asserted mid-transfer: all outputs take reset values immediately; a pending word is discarded.

## Configuration
- `SPI_MASTER_RX_ENDIAN_SWAP_EN`
  - Defined: the word written to the holding register is byte-swapped, i.e. {b[7:0], b[15:8], b[23:16], b[31:24]}. The swap also applies to partial words after right-justification.
  - Undefined: no swap; the word is presented as shifted.

## Test plan
- Standard 32 bits, `sdi1` pattern 0xA5C3_0F96, `data_ready`=1 → one word 0xA5C3_0F96; `rx_done` pulses one cycle after edge 32.
- Quad, `counter_in`=64, nibbles 0x1234_5678 then 0x9ABC_DEF0 → two words in order; `rx_done` after edge 16.
- Standard 12 bits, pattern 0xABC → `data` = 0x0000_0ABC; with `SPI_MASTER_RX_ENDIAN_SWAP_EN` → 0xBC0A_0000.
- Quad 96 bits, `data_ready`=0 → word 1 held; `clk_en_o`=0 before edge 16; raise `data_ready` → `clk_en_o`=1; all 3 words delivered intact.
- `counter_in_upd` after 10 standard edges, new `counter_in`=8 → prior partial bits discarded; one word holding 8 fresh bits.
- `rstn` low while `data_valid`=1 → `data_valid`=0, `data`=0, `clk_en_o`=1 immediately.
